pwm_ramp_scheduler: RTL



---
 rtl/pwm_ramp_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_ramp_scheduler.sv
// Ramps three PWM duty registers toward their targets, one load per arbitration
// slot over the shared write-data path, always yielding to host PWM writes.
//
// state | meaning
// IDLE  | nothing pending
// ARB   | pick next pending channel round-robin (waits while host writes)
// LOAD  | drive one step onto busdata/pwmld for the selected channel
// GAP   | hold off GAPCYC cycles after a load before re-arbitrating
module pwm_ramp_scheduler #(
    parameter int STEP   = 8,
    parameter int GAPCYC = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       tgtwe,
    input  logic [1:0] tgtsel,
    input  logic [7:0] tgtdata,
    input  logic [2:0] hostld,
    input  logic [7:0] hostdata,
    input  logic       stopreq,
    output logic [7:0] busdata,
    output logic [2:0] pwmld,
    output logic       busy,
    output logic [2:0] attarget,
    output logic [7:0] curduty0,
    output logic [7:0] curduty1,
    output logic [7:0] curduty2
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_LOAD = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [7:0] STEP8    = 8'(STEP);
    localparam logic [3:0] GAP_LOAD = (GAPCYC < 1) ? 4'd0 : 4'(GAPCYC - 1);

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      rr_q, rr_d;
    logic [3:0]      gap_q, gap_d;
    logic [2:0]      pend_q, pend_d;
    logic [2:0][7:0] tgt_q, tgt_d;
    logic [2:0][7:0] cur_q, cur_d;
    logic [7:0]      bus_q, bus_d;

    logic [2:0] pwmld_c;
    logic [2:0] clr;
    logic [2:0] sel_oh;
    logic [7:0] cur_s, tgt_s, diff, mag, nxt;
    logic [1:0] pick;
    logic       found;

    always_comb begin
        case (sel_q)
            2'd1:    begin cur_s = cur_q[1]; tgt_s = tgt_q[1]; end
            2'd2:    begin cur_s = cur_q[2]; tgt_s = tgt_q[2]; end
            default: begin cur_s = cur_q[0]; tgt_s = tgt_q[0]; end
        endcase
    end

    // Differences never borrow in the chosen direction, and mag <= diff, so
    // the step cannot overshoot the target or wrap past 0/255.
    always_comb begin
        diff = (tgt_s > cur_s) ? (tgt_s - cur_s) : (cur_s - tgt_s);
        mag  = (diff > STEP8) ? STEP8 : diff;
        nxt  = (tgt_s > cur_s) ? (cur_s + mag) : (cur_s - mag);
    end

    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                if (!found && pend_q[c] && (c == (int'(rr_q) + k) % 3)) begin
                    found = 1'b1;
                    pick  = 2'(c);
                end
            end
        end
    end

    assign sel_oh = 3'b001 << sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        bus_d   = bus_q;
        pwmld_c = 3'b000;
        clr     = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 3'b000) state_d = S_ARB;
            end
            S_ARB: begin
                if (hostld == 3'b000) begin
                    if (!found) begin
                        state_d = S_IDLE;
                    end else begin
                        sel_d   = pick;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (hostld != 3'b000) begin
                    state_d = S_ARB;
                end else begin
                    clr     = sel_oh;
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                    if (cur_s != tgt_s) begin
                        pwmld_c = sel_oh;
                        bus_d   = nxt;
                        rr_d    = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = (pend_q != 3'b000) ? S_ARB : S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < 3; i++) begin
            if (pwmld_c[i]) cur_d[i] = nxt;
        end

        // Tick re-arms any off-target channel after the FSM's own clear.
        pend_d = pend_q & ~clr;
        if (tick) pend_d = pend_d | ~attarget;

        if (stopreq) begin
            tgt_d = '0;
        end else if (tgtwe) begin
            for (int i = 0; i < 3; i++) begin
                if (tgtsel == 2'(i)) tgt_d[i] = tgtdata;
            end
        end

        for (int i = 0; i < 3; i++) begin
            if (hostld[i]) begin
                cur_d[i]  = hostdata;
                tgt_d[i]  = hostdata;
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            rr_q    <= 2'd0;
            gap_q   <= 4'd0;
            pend_q  <= 3'b000;
            tgt_q   <= '0;
            cur_q   <= '0;
            bus_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            attarget[i] = (cur_q[i] == tgt_q[i]);
        end
    end

    assign pwmld    = pwmld_c;
    assign busdata  = bus_d;
    assign busy     = (state_q != S_IDLE);
    assign curduty0 = cur_q[0];
    assign curduty1 = cur_q[1];
    assign curduty2 = cur_q[2];

endmodule
